dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's req/ready data-memory interface.
- Accepts a request from SOC_TOP's dmem port and services it from an internal word-addressed scratchpad after a configurable latency.
- Returns a one-cycle ready pulse, with read data on reads.
- Drop-in replacement for the external MEMORY_TOP data port in block-level and SoC benches.

Parameters:
DWidth, 32, data/address width in bits
Depth, 1024, scratchpad size in words
BaseAddr, 32'h00004000, byte address of word 0 (DMemStart)
Latency, 3, cycles from request acceptance to ready_o pulse; legal range 1..15
ErrData, 32'hDEADBEEF, rdata_o value returned for out-of-range reads

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_i  input  1  request from initiator; held high until ready_o
write_i  input  1  1 = write, 0 = read; valid with req_i
addr_i  input  DWidth  byte address; addr_i[1:0] ignored
wdata_i  input  DWidth  write data; valid with req_i and write_i
ready_o  output  1  one-cycle completion pulse
rdata_o  output  DWidth  read data; valid while ready_o=1, held afterwards
err_o  output  1  pulses with ready_o when the address is out of range
busy_o  output  1  high from acceptance through the ready cycle

Behaviour:
- Reset (async assert, sync deassert at the clock edge): state=IDLE, ready_o=0, rdata_o=0, err_o=0, busy_o=0, latency counter=0. Scratchpad contents are not reset.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - On a clock edge with req_i=1: latch write_i, addr_i, wdata_i; load counter=Latency-1; go to WAIT.
  - busy_o asserts in the next cycle.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0: perform the access using the latched request and go to RESP.
  - Latency=1: WAIT lasts one cycle, so ready_o is high in the 2nd cycle after the acceptance edge.
  - Overall: ready_o rises exactly Latency+1 cycles after the cycle in which req_i was sampled.
- Access performed at the WAIT->RESP edge:
  - Word index = (addr - BaseAddr) >> 2.
  - In range (BaseAddr <= addr < BaseAddr+Depth*4):
    - Write: store wdata, rdata_o unchanged.
    - Read: rdata_o = mem[index].
  - Out of range: no memory update; a read loads rdata_o=ErrData; err_o=1 during RESP.
- RESP:
  - ready_o=1, busy_o=1 for exactly one cycle, then return to IDLE.
  - req_i is not sampled in RESP. The initiator drops or re-presents req_i; a still-high req_i is taken as a new request at the following IDLE edge (minimum 1 idle cycle between transactions).
- Protocol violations:
  - req_i dropping during WAIT does not abort; the latched transaction completes normally.
  - Changes to addr_i or wdata_i during WAIT are ignored.
- Read-after-write: a read issued after a write's ready pulse returns the new data. No write/read hazard is possible, since only one transaction is in flight.
- Reset mid-transaction: if asserted before the WAIT->RESP edge, no write is committed and ready_o stays low.
- Address arithmetic uses DWidth-bit unsigned compare. No wrap-around: addr below BaseAddr is out of range.

Optional Feature:
- Macro DMEM_RESPONDER_STATS_EN.
- Defined:
  - Adds ports rd_cnt_o and wr_cnt_o (output, 32 bits each).
  - Each increments at the WAIT->RESP edge of a read or write respectively; out-of-range accesses are counted too.
  - Saturate at 32'hFFFFFFFF; reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then idle 5 cycles -> ready_o=0, busy_o=0, err_o=0, rdata_o=0 throughout.
- Write 32'hCAFE0001 to 32'h00004010, then read 32'h00004010 -> each ready_o pulse comes exactly 4 cycles after req_i sampled (Latency=3); read rdata_o=32'hCAFE0001, err_o=0.
- Read 32'h00003FFC and 32'h00005000 (out of range) -> rdata_o=32'hDEADBEEF, err_o=1 with ready_o; a following in-range read of the last word 32'h00004FFC returns its prior write value with err_o=0.
- Hold req_i high continuously for 3 reads to 32'h00004000/4/8 -> 3 ready pulses separated by one idle cycle; data matches preloaded words.
- Assert rst_i 2 cycles into a write to 32'h00004020 (old value 32'h11111111) -> no ready pulse; a subsequent read returns 32'h11111111.
- With DMEM_RESPONDER_STATS_EN: 3 writes + 2 reads (1 out of range) -> wr_cnt_o=3, rd_cnt_o=2; after rst_i both are 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's req/ready data port.
// Accepts one request at a time and services it from a word-addressed
// scratchpad. The ready_o pulse comes Latency+1 cycles after the cycle in
// which req_i was sampled. Out-of-range accesses complete with err_o set.
// Optional feature macro: DMEM_RESPONDER_STATS_EN adds saturating read/write
// access counters on rd_cnt_o / wr_cnt_o.
module dmem_responder #(
  parameter int unsigned       DWidth   = 32,
  parameter int unsigned       Depth    = 1024,
  parameter logic [DWidth-1:0] BaseAddr = 32'h00004000,
  parameter int unsigned       Latency  = 3,
  parameter logic [DWidth-1:0] ErrData  = 32'hDEADBEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam int unsigned       AddrBits  = $clog2(Depth);
  localparam logic [DWidth-1:0] SpanBytes = DWidth'(Depth * 4);
  localparam logic [3:0]        LatLoad   = 4'(Latency - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [3:0]          cnt_r;
  logic                write_r;
  logic [DWidth-1:0]   addr_r;
  logic [DWidth-1:0]   wdata_r;
  logic                ready_r;
  logic                err_r;
  logic                busy_r;
  logic [DWidth-1:0]   rdata_r;
  logic                accept_s;
  logic                access_s;
  logic [DWidth-1:0]   offset_s;
  logic                in_range_s;
  logic [AddrBits-1:0] index_s;
  logic [DWidth-1:0]   mem_r [Depth];

  // Address decode of the latched request: unsigned compare, no wrap-around,
  // so anything below BaseAddr is out of range.
  always_comb begin
    offset_s   = addr_r - BaseAddr;
    in_range_s = (addr_r >= BaseAddr) && (offset_s < SpanBytes);
    index_s    = offset_s[AddrBits+1:2];
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic plus the accept and access strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_i) begin
          state_nxt_s = ST_WAIT;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
          access_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      // req_i is deliberately ignored here; a held request is taken in IDLE.
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request latch and latency counter; inputs are frozen at acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r   <= 4'd0;
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      cnt_r   <= LatLoad;
      write_r <= write_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r   <= cnt_r - 4'd1;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Registered response outputs; rdata_r holds its value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= access_s;
      err_r   <= access_s & ~in_range_s;
      busy_r  <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_RESP);
      if (access_s && !write_r) begin
        rdata_r <= in_range_s ? mem_r[index_s] : ErrData;
      end
    end
  end

  // Scratchpad write port; contents survive reset, and an aborted
  // transaction never reaches the access edge so nothing is committed.
  always_ff @(posedge clk_i) begin
    if (access_s && write_r && in_range_s) begin
      mem_r[index_s] <= wdata_r;
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_r;
  logic [31:0] wr_cnt_r;

  // Saturating access counters, out-of-range accesses included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else if (access_s) begin
      if (write_r && (wr_cnt_r != 32'hFFFFFFFF)) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
      if (!write_r && (rd_cnt_r != 32'hFFFFFFFF)) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;
`endif

  assign ready_o = ready_r;
  assign err_o   = err_r;
  assign busy_o  = busy_r;
  assign rdata_o = rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic,
// compared against a transaction-level model of the scratchpad.
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  dmem_responder dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .ready_o (ready_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    .rd_cnt_o(rd_cnt_o),
    .wr_cnt_o(wr_cnt_o)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl_mem [0:1023];
  logic [31:0] exp_rdata;
  int          mdl_rd;
  int          mdl_wr;
  logic [31:0] wr_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h00004000) && (a < 32'h00005000);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - 32'h00004000) >> 2);
  endfunction

  // One transaction. Called #1 after a clock edge. exp_lat is the number of
  // edges until ready_o is seen: 4 for a fresh request, 5 for a request
  // presented during the previous transaction's ready cycle.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input bit keep_req, input bit scramble);
    int   lat;
    bit   seen;
    logic exp_err;
    write_i = w;
    addr_i  = a;
    wdata_i = d;
    req_i   = 1'b1;
    exp_err = !in_rng(a);
    if (w) begin
      mdl_wr++;
      if (in_rng(a)) mdl_mem[word_idx(a)] = d;
    end else begin
      mdl_rd++;
      exp_rdata = in_rng(a) ? mdl_mem[word_idx(a)] : 32'hDEADBEEF;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (ready_o) begin
        seen = 1'b1;
      end else begin
        if (exp_lat == 5 && lat == 1) check_eq("busy_gap", 32'(busy_o), 32'd0);
        else                          check_eq("busy_wait", 32'(busy_o), 32'd1);
        if (scramble) begin
          addr_i  = $urandom;
          wdata_i = $urandom;
          if ($urandom_range(0, 2) == 0) req_i = 1'b0;
        end
      end
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("rdata", rdata_o, exp_rdata);
    check_eq("err", 32'(err_o), 32'(exp_err));
    check_eq("busy_rdy", 32'(busy_o), 32'd1);
    if (!keep_req) req_i = 1'b0;
  endtask

  // One cycle after a completed transaction: pulse gone, data held.
  task automatic idle_check();
    @(posedge clk_i);
    #1;
    check_eq("idle_ready", 32'(ready_o), 32'd0);
    check_eq("idle_busy", 32'(busy_o), 32'd0);
    check_eq("idle_err", 32'(err_o), 32'd0);
    check_eq("idle_rdata", rdata_o, exp_rdata);
  endtask

  task automatic stats_check();
`ifdef DMEM_RESPONDER_STATS_EN
    check_eq("rd_cnt", rd_cnt_o, 32'(mdl_rd));
    check_eq("wr_cnt", wr_cnt_o, 32'(mdl_wr));
`endif
  endtask

  initial begin
    logic [31:0] a;
    rst_i     = 1'b1;
    req_i     = 1'b0;
    write_i   = 1'b0;
    addr_i    = 32'd0;
    wdata_i   = 32'd0;
    exp_rdata = 32'd0;
    mdl_rd    = 0;
    mdl_wr    = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      check_eq("rst_ready", 32'(ready_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_err", 32'(err_o), 32'd0);
      check_eq("rst_rdata", rdata_o, 32'd0);
    end
    stats_check();

    // Write then read back.
    do_txn(1'b1, 32'h00004010, 32'hCAFE0001, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b0, 32'h00004010, 32'h0, 4, 1'b0, 1'b0);        idle_check();

    // Out-of-range reads, then the last in-range word.
    do_txn(1'b1, 32'h00004FFC, 32'h5A5A0FFC, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b0, 32'h00003FFC, 32'h0, 4, 1'b0, 1'b0);        idle_check();
    do_txn(1'b0, 32'h00005000, 32'h0, 4, 1'b0, 1'b0);        idle_check();
    do_txn(1'b0, 32'h00004FFC, 32'h0, 4, 1'b0, 1'b0);        idle_check();

    // Preload, then three reads with req_i held high throughout.
    do_txn(1'b1, 32'h00004000, 32'hA0000000, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b1, 32'h00004004, 32'hA0000004, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b1, 32'h00004008, 32'hA0000008, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b1, 32'h00004020, 32'h11111111, 4, 1'b0, 1'b0); idle_check();
    do_txn(1'b0, 32'h00004000, 32'h0, 4, 1'b1, 1'b0);
    do_txn(1'b0, 32'h00004004, 32'h0, 5, 1'b1, 1'b0);
    do_txn(1'b0, 32'h00004008, 32'h0, 5, 1'b0, 1'b0);        idle_check();
    stats_check();

    // Reset two cycles into a write: nothing committed, no ready pulse.
    write_i = 1'b1;
    addr_i  = 32'h00004020;
    wdata_i = 32'h22222222;
    req_i   = 1'b1;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    req_i = 1'b0;
    #2;
    check_eq("midrst_ready", 32'(ready_o), 32'd0);
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_rdata", rdata_o, 32'd0);
    exp_rdata = 32'd0;
    mdl_rd    = 0;
    mdl_wr    = 0;
    stats_check();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check_eq("midrst_nopulse", 32'(ready_o), 32'd0);
    end
    rst_i = 1'b0;
    do_txn(1'b0, 32'h00004020, 32'h0, 4, 1'b0, 1'b0);        idle_check();

    // Randomized traffic with input scrambling and req_i drops during WAIT.
    wr_q.push_back(32'h00004010);
    wr_q.push_back(32'h00004FFC);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          a = 32'h00005000 + (32'($urandom_range(0, 4095)) << 2);
        end else begin
          a = 32'h00004000 + (32'($urandom_range(0, 1023)) << 2);
          wr_q.push_back(a);
          a = a + 32'($urandom_range(0, 3));
        end
        do_txn(1'b1, a, $urandom, 4, 1'b0, 1'b1);
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          a = ($urandom_range(0, 1) == 1) ? (32'h00003FFC - (32'($urandom_range(0, 255)) << 2))
                                          : (32'h00005000 + (32'($urandom_range(0, 4095)) << 2));
        end else begin
          a = wr_q[$urandom_range(0, wr_q.size() - 1)] + 32'($urandom_range(0, 3));
        end
        do_txn(1'b0, a, 32'h0, 4, 1'b0, 1'b1);
      end
      idle_check();
    end
    stats_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
